// File: rtl/uart_rx_word.sv
// UART receiver that packs BPS/8 consecutive bytes (LSB byte first) into one word with a valid/ready output.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 87,
    parameter int BPS          = 16
) (
    input  logic           in_clk,
    input  logic           in_reset,
    input  logic           rx_serial,
    input  logic           in_ready,
    output logic [BPS-1:0] out_word,
    output logic           out_valid,
    output logic           out_frame_err,
    output logic           out_overrun
);

    localparam int NBYTES = BPS / 8;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

`ifdef UART_RX_PARITY_EN
    function automatic logic f_even_parity_ok(input logic [7:0] data, input logic par);
        return ((^data) == par);
    endfunction
`endif

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    state_t           r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_par_err;
    logic [IDX_W-1:0] r_byte_idx;
    logic [BPS-1:0]   r_asm;
    logic [BPS-1:0]   r_out_word;
    logic             r_out_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_fall;
    logic             w_stop_ok;
    logic [BPS-1:0]   w_word;

    assign out_word      = r_out_word;
    assign out_valid     = r_out_valid;
    assign out_frame_err = r_frame_err;
    assign out_overrun   = r_overrun;

    // Assembly register with the byte currently in the shifter merged into its slot.
    always_comb begin
        w_fall    = r_rx_prev & ~r_sync2;
        w_stop_ok = r_sync2 & ~r_par_err;
        w_word    = r_asm;
        w_word[{r_byte_idx, 3'b000} +: 8] = r_shift;
    end

    // Synchronizer, frame FSM, word assembly and output handshake.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rx_prev   <= 1'b1;
            r_state     <= S_IDLE;
            r_clk_cnt   <= '0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_par_err   <= 1'b0;
            r_byte_idx  <= '0;
            r_asm       <= '0;
            r_out_word  <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= rx_serial;
            r_sync2     <= r_sync1;
            r_rx_prev   <= r_sync2;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (r_out_valid && in_ready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= '0;
                    r_bit_cnt <= 3'd0;
                    r_par_err <= 1'b0;
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    // Mid-start check rejects short low glitches without reporting them.
                    if (r_clk_cnt == CNT_MID) begin
                        r_clk_cnt <= '0;
                        r_state   <= r_sync2 ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        r_par_err <= ~f_even_parity_ok(r_shift, r_sync2);
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_clk_cnt <= '0;
                        r_state   <= S_IDLE;
                        if (w_stop_ok) begin
                            r_asm <= w_word;
                            if (r_byte_idx == IDX_LAST) begin
                                r_byte_idx <= '0;
                                // A held word is only replaced when it is consumed in this same cycle.
                                if (!r_out_valid || in_ready) begin
                                    r_out_word  <= w_word;
                                    r_out_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end else begin
                                r_byte_idx <= r_byte_idx + IDX_W'(1);
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                            r_byte_idx  <= '0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: frame-level reference model plus a per-cycle output monitor.
module tb_uart_rx_word;

    localparam int C   = 87;
    localparam int BPS = 16;
    localparam int NB  = BPS / 8;

    logic           in_clk    = 1'b0;
    logic           in_reset  = 1'b1;
    logic           rx_serial = 1'b1;
    logic           in_ready  = 1'b1;
    logic [BPS-1:0] out_word;
    logic           out_valid;
    logic           out_frame_err;
    logic           out_overrun;

    always #5 in_clk = ~in_clk;

    uart_rx_word #(.CLKS_PER_BIT(C), .BPS(BPS)) dut (
        .in_clk(in_clk),
        .in_reset(in_reset),
        .rx_serial(rx_serial),
        .in_ready(in_ready),
        .out_word(out_word),
        .out_valid(out_valid),
        .out_frame_err(out_frame_err),
        .out_overrun(out_overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: bytes, word delivery and error counts at frame granularity.
    logic [7:0]     m_bytes[$];
    logic           m_valid = 1'b0;
    logic [BPS-1:0] m_word  = '0;
    int             m_fe = 0;
    int             m_ov = 0;
    logic [BPS-1:0] m_beats[$];

    // Observed DUT behaviour.
    int             d_fe = 0;
    int             d_ov = 0;
    logic [BPS-1:0] d_beats[$];
    logic [BPS-1:0] last_beat = '0;
    logic           prev_fe = 1'b0, prev_ov = 1'b0, prev_hold = 1'b0;
    logic [BPS-1:0] prev_word = '0;

    task automatic model_frame(input logic [7:0] d, input logic good);
        logic [BPS-1:0] w;
        if (!good) begin
            m_fe++;
            m_bytes.delete();
        end else begin
            m_bytes.push_back(d);
            if (m_bytes.size() == NB) begin
                w = '0;
                for (int i = 0; i < NB; i++) w = w | (BPS'(m_bytes[i]) << (8 * i));
                m_bytes.delete();
                if (m_valid && !in_ready) begin
                    m_ov++;
                end else begin
                    m_word = w;
                    if (in_ready) begin
                        m_beats.push_back(w);
                        m_valid = 1'b0;
                    end else begin
                        m_valid = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        m_bytes.delete();
        m_valid = 1'b0;
        m_word  = '0;
    endtask

    // Monitor: handshakes, pulse counts, pulse width and hold stability every cycle.
    always @(negedge in_clk) begin
        if (!in_reset) begin
            if (out_valid && in_ready) begin
                d_beats.push_back(out_word);
                last_beat = out_word;
            end
            if (out_frame_err) begin
                d_fe++;
                check("frame_err_width", 64'(prev_fe), 64'd0);
            end
            if (out_overrun) begin
                d_ov++;
                check("overrun_width", 64'(prev_ov), 64'd0);
            end
            if (prev_hold) begin
                check("valid_held", 64'(out_valid), 64'd1);
                check("word_stable", 64'(out_word), 64'(prev_word));
            end
        end
        prev_fe   = out_frame_err;
        prev_ov   = out_overrun;
        prev_hold = out_valid && !in_ready && !in_reset;
        prev_word = out_word;
    end

    task automatic drive_bit(input logic b);
        @(posedge in_clk); #1;
        rx_serial = b;
        repeat (C - 1) @(posedge in_clk);
    endtask

    // One frame; rst_bit >= 0 pulses reset mid data bit rst_bit and abandons the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip, input int rst_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                @(posedge in_clk); #1;
                rx_serial = d[i];
                repeat (C / 2) @(posedge in_clk);
                #1 in_reset = 1'b1;
                @(posedge in_clk); #1;
                in_reset  = 1'b0;
                rx_serial = 1'b1;
                model_reset();
                @(negedge in_clk);
                check("rst_word", 64'(out_word), 64'd0);
                check("rst_valid", 64'(out_valid), 64'd0);
                check("rst_pulses", 64'({out_frame_err, out_overrun}), 64'd0);
                repeat (12 * C) @(posedge in_clk);
                return;
            end
            drive_bit(d[i]);
        end
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_v);
        @(posedge in_clk); #1;
        rx_serial = 1'b1;
        repeat (2) @(posedge in_clk);
        model_frame(d, stop_v && !par_flip);
    endtask

    task automatic set_ready(input logic v);
        @(posedge in_clk); #1;
        in_ready = v;
        if (v && m_valid) begin
            m_beats.push_back(m_word);
            m_valid = 1'b0;
        end
        repeat (3) @(posedge in_clk);
    endtask

    task automatic checkpoint(input string tag);
        @(negedge in_clk); #1;
        check({tag, "/valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, "/word"}, 64'(out_word), 64'(m_word));
        check({tag, "/frame_err_cnt"}, 64'(d_fe), 64'(m_fe));
        check({tag, "/overrun_cnt"}, 64'(d_ov), 64'(m_ov));
        check({tag, "/beats"}, 64'(d_beats.size()), 64'(m_beats.size()));
        while (d_beats.size() > 0 && m_beats.size() > 0) begin
            check({tag, "/beat_word"}, 64'(d_beats.pop_front()), 64'(m_beats.pop_front()));
        end
        d_beats.delete();
        m_beats.delete();
    endtask

    initial begin
        repeat (5) @(posedge in_clk);
        @(negedge in_clk);
        check("reset_word", 64'(out_word), 64'd0);
        check("reset_flags", 64'({out_valid, out_frame_err, out_overrun}), 64'd0);
        @(posedge in_clk); #1;
        in_reset = 1'b0;
        repeat (20) @(posedge in_clk);

        // Two good bytes, consumer always ready.
        send_frame(8'h3F, 1'b1, 1'b0, -1);
        send_frame(8'h03, 1'b1, 1'b0, -1);
        checkpoint("pair");
        check("pair_literal", 64'(last_beat), 64'h033F);
        check("pair_no_err", 64'(d_fe + d_ov), 64'd0);

        // Consumer stalled: hold, partial byte, then overrun.
        set_ready(1'b0);
        send_frame(8'h33, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        send_frame(8'h01, 1'b1, 1'b0, -1);
        checkpoint("hold");
        check("hold_literal", 64'(out_word), 64'hFF33);
        check("hold_no_ovr", 64'(d_ov), 64'd0);
        send_frame(8'hF0, 1'b1, 1'b0, -1);
        checkpoint("overrun");
        check("overrun_literal", 64'(d_ov), 64'd1);
        check("overrun_word", 64'(out_word), 64'hFF33);
        set_ready(1'b1);
        checkpoint("drain");
        check("drain_literal", 64'(last_beat), 64'hFF33);

        // Bad stop bit discards the frame and the partial word.
        send_frame(8'hAA, 1'b0, 1'b0, -1);
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        checkpoint("stop_err");
        check("stop_err_literal", 64'(last_beat), 64'h2211);
        check("stop_err_cnt", 64'(d_fe), 64'd1);

        // Short low glitch on an idle line.
        @(posedge in_clk); #1;
        rx_serial = 1'b0;
        repeat (20) @(posedge in_clk);
        #1 rx_serial = 1'b1;
        repeat (200) @(posedge in_clk);
        checkpoint("glitch");
        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'h66, 1'b1, 1'b0, -1);
        checkpoint("after_glitch");
        check("glitch_literal", 64'(last_beat), 64'h6655);

        // Reset during bit 4 of the second byte of a word.
        send_frame(8'h77, 1'b1, 1'b0, -1);
        send_frame(8'h10, 1'b1, 1'b0, 4);
        checkpoint("mid_reset");
        send_frame(8'h01, 1'b1, 1'b0, -1);
        send_frame(8'h02, 1'b1, 1'b0, -1);
        checkpoint("after_reset");
        check("reset_literal", 64'(last_beat), 64'h0201);

`ifdef UART_RX_PARITY_EN
        // Good parity accepted, bad parity is a frame error that drops the partial word.
        send_frame(8'h07, 1'b1, 1'b0, -1);
        send_frame(8'h07, 1'b1, 1'b1, -1);
        send_frame(8'h34, 1'b1, 1'b0, -1);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        checkpoint("parity");
        check("parity_literal", 64'(last_beat), 64'h1234);
        check("parity_err_cnt", 64'(d_fe), 64'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
